// File: rtl/data_ram_rd_pkg.sv
// data_ram_rd_pkg: shared state encoding and read-latency derivation
package data_ram_rd_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  function automatic int rd_lat(input bit oreg);
    return oreg ? 2 : 1;
  endfunction
endpackage

// File: rtl/data_ram_rd_fifo.sv
// data_ram_rd_fifo: synchronous FIFO with occupancy count, registered-only output
module data_ram_rd_fifo #(
  parameter int DWIDTH = 128,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] din,
  input  logic              pop,
  output logic [DWIDTH-1:0] dout,
  output logic [CW-1:0]     count
);
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end
  assign dout = mem_q[rptr_q];
  assign count = count_q;
endmodule

// File: rtl/data_ram_rd_streamer.sv
// data_ram_rd_streamer: credit-managed burst reader from RAM port B to a valid/ready stream
module data_ram_rd_streamer
  import data_ram_rd_pkg::*;
#(
  parameter int    AWIDTH = 12,
  parameter int    DWIDTH = 128,
  parameter string OREG_B = "TRUE",
  parameter int    FIFO_DEPTH = 4,
  parameter int    LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AWIDTH-1:0]    cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  output logic                 en_b,
  output logic                 we_b,
  output logic [AWIDTH-1:0]    addr_b,
  output logic                 oreg_ce_b,
  input  logic [DWIDTH-1:0]    rd_data_b,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DWIDTH-1:0]    m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);
  localparam int RD_LAT = rd_lat(OREG_B == "TRUE");
  localparam int BW = LEN_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_e state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [BW-1:0] left_q, left_d, total_q, total_d, popped_q, popped_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [CW-1:0] fifo_count;
  logic pop, credit;
  always_comb begin
    credit = $countones(pipe_q) + int'(fifo_count) < FIFO_DEPTH;
    en_b = state_q == RUN && left_q != '0 && credit;
    m_valid = fifo_count != '0;
    pop = m_valid && m_ready;
    m_last = m_valid && popped_q + BW'(1) == total_q;
    done = pop && m_last;
    pipe_d = RD_LAT'({pipe_q, en_b});
    state_d = state_q;
    addr_d = en_b ? addr_q + AWIDTH'(1) : addr_q;
    left_d = en_b ? left_q - BW'(1) : left_q;
    total_d = total_q;
    popped_d = pop ? popped_q + BW'(1) : popped_q;
    if (state_q == IDLE && cmd_valid) begin
      state_d = RUN;
      addr_d = cmd_addr;
      left_d = {1'b0, cmd_len} + BW'(1);
      total_d = {1'b0, cmd_len} + BW'(1);
      popped_d = '0;
    end
    if (en_b && left_q == BW'(1)) state_d = DRAIN;
    if (done) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      left_q <= '0;
      total_q <= '0;
      popped_q <= '0;
      pipe_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      left_q <= left_d;
      total_q <= total_d;
      popped_q <= popped_d;
      pipe_q <= pipe_d;
    end
  end
  data_ram_rd_fifo #(.DWIDTH(DWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(pipe_q[RD_LAT-1]),
    .din(rd_data_b),
    .pop(pop),
    .dout(m_data),
    .count(fifo_count)
  );
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign we_b = 1'b0;
  assign oreg_ce_b = 1'b1;
  assign addr_b = addr_q;
endmodule

// File: tb/tb_data_ram_rd_streamer.sv
// tb_data_ram_rd_streamer: table-driven and randomized bursts checked against an address-sequence model
module tb_data_ram_rd_streamer;
  localparam int AW = 12;
  localparam int DW = 128;
  localparam int LW = 8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic cmd_valid, cmd_ready, en_b, we_b, oreg_ce_b, m_valid, m_ready, m_last, busy, done;
  logic [AW-1:0] cmd_addr, addr_b;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] rd_data_b, m_data, r1, r2;
  logic cmd_valid_f, cmd_ready_f, en_b_f, we_b_f, oreg_ce_b_f, m_valid_f, m_ready_f, m_last_f, busy_f, done_f;
  logic [AW-1:0] cmd_addr_f, addr_b_f;
  logic [LW-1:0] cmd_len_f;
  logic [DW-1:0] rd_data_b_f, m_data_f, r1f;
  data_ram_rd_streamer #(.AWIDTH(AW), .DWIDTH(DW), .OREG_B("TRUE"), .FIFO_DEPTH(4), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .oreg_ce_b(oreg_ce_b),
    .rd_data_b(rd_data_b), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done)
  );
  data_ram_rd_streamer #(.AWIDTH(AW), .DWIDTH(DW), .OREG_B("FALSE"), .FIFO_DEPTH(4), .LEN_WIDTH(LW)) dut_f (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_f), .cmd_ready(cmd_ready_f), .cmd_addr(cmd_addr_f),
    .cmd_len(cmd_len_f), .en_b(en_b_f), .we_b(we_b_f), .addr_b(addr_b_f), .oreg_ce_b(oreg_ce_b_f),
    .rd_data_b(rd_data_b_f), .m_valid(m_valid_f), .m_ready(m_ready_f), .m_data(m_data_f),
    .m_last(m_last_f), .busy(busy_f), .done(done_f)
  );
  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    logic [31:0] h;
    h = {20'h5A5A5, a} * 32'h9E3779B1;
    return {h, ~h, h ^ 32'hDEADBEEF, {20'h0, a}};
  endfunction
  always @(posedge clk) begin
    if (en_b) r1 <= word(addr_b);
    r2 <= r1;
    if (en_b_f) r1f <= word(addr_b_f);
  end
  assign rd_data_b = r2;
  assign rd_data_b_f = r1f;
  int tests = 0;
  int fails = 0;
  int rdy_pct = 100;
  task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    m_ready = $urandom_range(99) < rdy_pct;
  end
  logic [DW-1:0] got_q[$];
  logic got_last_q[$];
  logic [AW-1:0] issued_q[$];
  int done_cnt;
  logic stall_p = 1'b0;
  logic stall_l;
  logic [DW-1:0] stall_d;
  always @(negedge clk) begin
    if (rst) stall_p = 1'b0;
    else begin
      if (stall_p) chk("hold_stable", DW'({m_valid, m_last}), DW'({1'b1, stall_l}));
      if (stall_p) chk("hold_data", m_data, stall_d);
      if (en_b) issued_q.push_back(addr_b);
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_last_q.push_back(m_last);
      end
      if (done) done_cnt++;
      stall_p = m_valid && !m_ready;
      stall_l = m_last;
      stall_d = m_data;
    end
  end
  task automatic start_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    got_q.delete();
    got_last_q.delete();
    issued_q.delete();
    done_cnt = 0;
    @(posedge clk);
    #1;
    chk("cmd_ready_idle", DW'(cmd_ready), DW'(1));
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_len = l;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask
  task automatic finish_check(input logic [AW-1:0] a, input int n, input logic [AW-1:0] exp_last);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_pulses", DW'(done_cnt), DW'(1));
    chk("beats", DW'(got_q.size()), DW'(n));
    chk("issued", DW'(issued_q.size()), DW'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      chk("beat_data", got_q[i], word(AW'((int'(a) + i) % 4096)));
      chk("beat_last", DW'(got_last_q[i]), DW'(i == n - 1));
    end
    for (int i = 0; i < n && i < issued_q.size(); i++)
      chk("addr_b", DW'(issued_q[i]), DW'((int'(a) + i) % 4096));
    if (issued_q.size() > 0) chk("last_addr", DW'(issued_q[$]), DW'(exp_last));
  endtask
  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int rdy;
    int exp_beats;
    logic [AW-1:0] exp_last;
  } vec_t;
  vec_t vt[6];
  initial begin
    vt[0] = '{12'h010, 8'd3, 100, 4, 12'h013};
    vt[1] = '{12'hFFE, 8'd3, 100, 4, 12'h001};
    vt[2] = '{12'h123, 8'd0, 100, 1, 12'h123};
    vt[3] = '{12'h7F0, 8'd15, 60, 16, 12'h7FF};
    vt[4] = '{12'hFFF, 8'd255, 80, 256, 12'h0FE};
    vt[5] = '{12'h200, 8'd7, 30, 8, 12'h207};
    rst = 1'b1;
    m_ready = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    cmd_valid_f = 1'b0;
    cmd_addr_f = '0;
    cmd_len_f = '0;
    m_ready_f = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", DW'({en_b, addr_b, m_valid, m_last, busy, done, cmd_ready, we_b, oreg_ce_b}),
        DW'({1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}));
    rst = 1'b0;
    foreach (vt[k]) begin
      rdy_pct = vt[k].rdy;
      start_cmd(vt[k].addr, vt[k].len);
      finish_check(vt[k].addr, vt[k].exp_beats, vt[k].exp_last);
    end
    for (int k = 0; k < 10; k++) begin
      logic [AW-1:0] a;
      logic [LW-1:0] l;
      a = AW'($urandom_range(0, 4095));
      l = LW'($urandom_range(0, 40));
      rdy_pct = $urandom_range(20, 100);
      start_cmd(a, l);
      finish_check(a, int'(l) + 1, AW'((int'(a) + int'(l)) % 4096));
    end
    rdy_pct = 50;
    start_cmd(12'h400, 8'd15);
    repeat (10) @(posedge clk);
    rdy_pct = 0;
    repeat (20) @(negedge clk);
    chk("stall_en_b", DW'(en_b), DW'(0));
    chk("stall_outstanding", DW'(issued_q.size() - got_q.size()), DW'(4));
    chk("stall_valid", DW'(m_valid), DW'(1));
    rdy_pct = 100;
    finish_check(12'h400, 16, 12'h40F);
    rdy_pct = 100;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr = 12'h055;
    cmd_len = 8'd0;
    @(negedge clk);
    chk("t_accept_ready", DW'(cmd_ready), DW'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t1_en_b", DW'({en_b, addr_b, busy, cmd_ready}), DW'({1'b1, 12'h055, 1'b1, 1'b0}));
    @(negedge clk);
    chk("t2_en_b_off", DW'(en_b), DW'(0));
    @(negedge clk);
    chk("t3_no_fallthrough", DW'(m_valid), DW'(0));
    @(negedge clk);
    chk("t4_beat", DW'({m_valid, m_last, done}), DW'({1'b1, 1'b1, 1'b1}));
    chk("t4_data", m_data, word(12'h055));
    @(negedge clk);
    chk("t5_idle", DW'({cmd_ready, done, busy, m_valid}), DW'({1'b1, 1'b0, 1'b0, 1'b0}));
    start_cmd(12'h300, 8'd31);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_outputs", DW'({en_b, addr_b, m_valid, m_last, busy, done, cmd_ready}),
        DW'({1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    start_cmd(12'h100, 8'd1);
    finish_check(12'h100, 2, 12'h101);
    @(posedge clk);
    #1;
    cmd_valid_f = 1'b1;
    cmd_addr_f = 12'h0A0;
    cmd_len_f = 8'd7;
    @(negedge clk);
    chk("f_accept_ready", DW'(cmd_ready_f), DW'(1));
    @(posedge clk);
    #1;
    cmd_valid_f = 1'b0;
    @(negedge clk);
    chk("f_t1_en_b", DW'({en_b_f, m_valid_f}), DW'({1'b1, 1'b0}));
    @(negedge clk);
    chk("f_t2_no_valid", DW'(m_valid_f), DW'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("f_beat_valid", DW'({m_valid_f, m_last_f}), DW'({1'b1, i == 7}));
      chk("f_beat_data", m_data_f, word(AW'(12'h0A0 + i)));
    end
    @(negedge clk);
    chk("f_end", DW'({m_valid_f, cmd_ready_f}), DW'({1'b0, 1'b1}));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
